// File: rtl/mem_loader.sv
// Boot-time loader: streams 32-bit words into a byte-wide data memory, holding the CPU in reset.
// Optional MEM_LOADER_CHECKSUM_EN adds a running modulo-2^32 sum of written words.
module mem_loader #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-2:0] word_count
`ifdef MEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

    state_e            state;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       word_q;
    logic              last_q;
    logic [1:0]        byte_idx;

    logic [31:0]       end_byte;
    logic [ADDR_W-1:0] word_addr;
    logic [1:0]        next_idx;

    // Overflow check is done 32 bits wide so a wrapped address can never look in range.
    always_comb begin
        end_byte  = 32'(base_q) + 32'({word_count, 2'b00}) + 32'd3;
        word_addr = base_q + ADDR_W'({word_count, 2'b00});
        next_idx  = byte_idx + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            base_q     <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            byte_idx   <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state      <= StAccept;
                        base_q     <= {base_addr[ADDR_W-1:2], 2'b00};
                        word_count <= '0;
                        err        <= 1'b0;
                        in_ready   <= 1'b1;
                        cpu_rst    <= 1'b1;
                        done       <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
                        checksum   <= '0;
`endif
                    end
                end
                StAccept: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (end_byte < DEPTH) begin
                            state     <= StWrite;
                            word_q    <= in_data;
                            last_q    <= in_last;
                            byte_idx  <= '0;
                            mem_we    <= 1'b1;
                            mem_addr  <= word_addr;
                            mem_wdata <= in_data[7:0];
                        end else begin
                            // Word is consumed and dropped; the load ends regardless of in_last.
                            state   <= StDone;
                            err     <= 1'b1;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end
                    end
                end
                StWrite: begin
                    if (byte_idx == 2'd3) begin
                        mem_we     <= 1'b0;
                        word_count <= word_count + 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
                        checksum   <= checksum + word_q;
`endif
                        if (last_q) begin
                            state   <= StDone;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state    <= StAccept;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        byte_idx  <= next_idx;
                        mem_addr  <= mem_addr + 1'b1;
                        mem_wdata <= word_q[{next_idx, 3'b000} +: 8];
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
